// File: rtl/sel16to4_rr_if.sv
// Handshake bundle for the round-robin line-event encoder.
// The master drives requests and ready; the slave presents the granted index.
interface sel16to4_rr_if #(
  parameter int LIMIT = 4
);
  logic [2**LIMIT-1:0] path;
  logic                ready;
  logic [LIMIT-1:0]    select;
  logic                valid;
  logic [LIMIT:0]      pending_cnt;
  logic                overflow;

  modport master (
    output path, ready,
    input  select, valid, pending_cnt, overflow
  );

  modport slave (
    input  path, ready,
    output select, valid, pending_cnt, overflow
  );
endinterface

// File: rtl/sel16to4_rr.sv
// Captures one-hot line events into a pending register and hands them out
// one binary index per handshake, choosing among pending lines round-robin.
module sel16to4_rr #(
  parameter int LIMIT = 4
) (
  input logic         clk1,
  input logic         rst,
  sel16to4_rr_if.slave bus
);
  localparam int N = 2**LIMIT;

  logic [N-1:0]     pend_q, pend_d;
  logic [LIMIT-1:0] ptr_q;
  logic [LIMIT-1:0] select_q;
  logic             valid_q;
  logic [LIMIT:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [LIMIT-1:0] grantIdx;
  logic [LIMIT-1:0] scanIdx;
  logic             found;
  logic             load;
  logic [N-1:0]     clr;

  // Scan upward from ptr with natural wrap of the LIMIT-bit index.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    scanIdx  = '0;
    for (int i = 0; i < N; i++) begin
      scanIdx = ptr_q + LIMIT'(i);
      if (!found && pend_q[scanIdx]) begin
        found    = 1'b1;
        grantIdx = scanIdx;
      end
    end
  end

  assign load = (!valid_q || bus.ready) && (pend_q != '0);
  assign clr  = load ? (N'(1) << grantIdx) : '0;

  // A request on a bit being cleared this cycle is a fresh event, not an overflow.
  always_comb begin
    pend_d = (pend_q & ~clr) | bus.path;
    ovf_d  = |(bus.path & pend_q & ~clr);
    cnt_d  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d = cnt_d + (LIMIT+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      pend_q   <= '0;
      ptr_q    <= '0;
      select_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      if (load) begin
        select_q <= grantIdx;
        valid_q  <= 1'b1;
        ptr_q    <= grantIdx + LIMIT'(1);
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.select      = select_q;
  assign bus.valid       = valid_q;
  assign bus.pending_cnt = cnt_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_sel16to4_rr.sv
// Directed bench for sel16to4_rr: each scenario steps a table of inputs and
// compares the packed output {valid, select, pending_cnt, overflow} per cycle.
module tb_sel16to4_rr;
  localparam int LIMIT = 4;

  logic clk1 = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   errorCount = 0;

  sel16to4_rr_if #(.LIMIT(LIMIT)) bus ();

  sel16to4_rr #(.LIMIT(LIMIT)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk1 = ~clk1;

  logic [10:0] obs;
  assign obs = {bus.valid, bus.select, bus.pending_cnt, bus.overflow};

  function automatic logic [10:0] pk(input logic v, input int s, input int c, input logic o);
    return {v, 4'(s), 5'(c), o};
  endfunction

  // Inputs are applied, then the edge is taken and outputs settle 1ns later.
  task automatic applyStimulus(input logic [15:0] p, input logic r, input logic rs);
    bus.path  = p;
    bus.ready = r;
    rst       = rs;
    @(posedge clk1);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(16'h0000, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    applyStimulus(16'hFFFF, 1'b1, 1'b1);
    applyStimulus(16'hFFFF, 1'b1, 1'b1);
    checkCount++;
    if (obs !== 11'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_state: got %h want %h", obs, 11'd0);
    end
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkCount++;
    if (obs !== 11'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_discard: got %h want %h", obs, 11'd0);
    end
  endtask

  task automatic test_single_event();
    logic [15:0] p [3];
    logic [10:0] w [3];
    p = '{16'h0020, 16'h0000, 16'h0000};
    w = '{pk(0,0,1,0), pk(1,5,0,0), pk(0,5,0,0)};
    resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(p[i], 1'b1, 1'b0);
      checkCount++;
      if (obs !== w[i]) begin
        errorCount++;
        $display("[TB] FAIL single_event step %0d: got %h want %h", i, obs, w[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] p [5];
    logic [10:0] w [5];
    p = '{16'h8011, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    w = '{pk(0,0,3,0), pk(1,0,2,0), pk(1,4,1,0), pk(1,15,0,0), pk(0,15,0,0)};
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(p[i], 1'b1, 1'b0);
      checkCount++;
      if (obs !== w[i]) begin
        errorCount++;
        $display("[TB] FAIL round_robin step %0d: got %h want %h", i, obs, w[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] p [8];
    logic        r [8];
    logic [10:0] w [8];
    p = '{16'h0006, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    w = '{pk(0,0,2,0), pk(1,1,1,0), pk(1,1,1,0), pk(1,1,1,0), pk(1,1,1,0),
          pk(1,1,1,0), pk(1,2,0,0), pk(0,2,0,0)};
    resetDut();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(p[i], r[i], 1'b0);
      checkCount++;
      if (obs !== w[i]) begin
        errorCount++;
        $display("[TB] FAIL stall step %0d: got %h want %h", i, obs, w[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] p [8];
    logic        r [8];
    logic [10:0] w [8];
    p = '{16'h0001, 16'h0000, 16'h0008, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    w = '{pk(0,0,1,0), pk(1,0,0,0), pk(1,0,1,0), pk(1,0,1,1), pk(1,0,1,0),
          pk(1,3,0,0), pk(0,3,0,0), pk(0,3,0,0)};
    resetDut();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(p[i], r[i], 1'b0);
      checkCount++;
      if (obs !== w[i]) begin
        errorCount++;
        $display("[TB] FAIL overflow step %0d: got %h want %h", i, obs, w[i]);
      end
    end
  endtask

  task automatic test_same_bit_clear();
    logic [15:0] p [4];
    logic [10:0] w [4];
    p = '{16'h0004, 16'h0004, 16'h0000, 16'h0000};
    w = '{pk(0,0,1,0), pk(1,2,1,0), pk(1,2,0,0), pk(0,2,0,0)};
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(p[i], 1'b1, 1'b0);
      checkCount++;
      if (obs !== w[i]) begin
        errorCount++;
        $display("[TB] FAIL same_bit step %0d: got %h want %h", i, obs, w[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] p [5];
    logic [10:0] w [5];
    p = '{16'h2000, 16'h4001, 16'h0000, 16'h0000, 16'h0000};
    w = '{pk(0,0,1,0), pk(1,13,2,0), pk(1,14,1,0), pk(1,0,0,0), pk(0,0,0,0)};
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(p[i], 1'b1, 1'b0);
      checkCount++;
      if (obs !== w[i]) begin
        errorCount++;
        $display("[TB] FAIL wrap step %0d: got %h want %h", i, obs, w[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] w;
    resetDut();
    applyStimulus(16'hFFFF, 1'b1, 1'b0);
    w = pk(0,0,16,0);
    checkCount++;
    if (obs !== w) begin
      errorCount++;
      $display("[TB] FAIL drain_fill: got %h want %h", obs, w);
    end
    for (int k = 0; k < 16; k++) begin
      applyStimulus(16'h0000, 1'b1, 1'b0);
      w = pk(1, k, 15 - k, 0);
      checkCount++;
      if (obs !== w) begin
        errorCount++;
        $display("[TB] FAIL drain index %0d: got %h want %h", k, obs, w);
      end
    end
    applyStimulus(16'h0000, 1'b1, 1'b0);
    w = pk(0,15,0,0);
    checkCount++;
    if (obs !== w) begin
      errorCount++;
      $display("[TB] FAIL drain_idle: got %h want %h", obs, w);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p  [5];
    logic        r  [5];
    logic        rs [5];
    logic [10:0] w  [5];
    p  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    r  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    w  = '{pk(0,0,16,0), pk(1,0,16,1), pk(0,0,0,0), pk(0,0,0,0), pk(0,0,0,0)};
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(p[i], r[i], rs[i]);
      checkCount++;
      if (obs !== w[i]) begin
        errorCount++;
        $display("[TB] FAIL reset_mid step %0d: got %h want %h", i, obs, w[i]);
      end
    end
  endtask

  initial begin
    bus.path  = '0;
    bus.ready = 1'b0;
    rst       = 1'b1;
    test_reset();
    test_single_event();
    test_round_robin();
    test_stall();
    test_overflow();
    test_same_bit_clear();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/sel16to4_rr.md
SEL16TO4_RR -- requirements
Module: sel16to4_rr

Interface
REQ-001 Parameter: LIMIT, default 4, code width in bits; the block has 2**LIMIT request lines; LIMIT 2..5 SHALL be supported.
REQ-002 clk1  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 path  input  2**LIMIT  one-bit-per-line event requests, any number may be high per cycle.
REQ-005 ready  input  1  consumer accepts the presented code this cycle when high with valid.
REQ-006 select  output  LIMIT  encoded index of the granted line, registered.
REQ-007 valid  output  1  select holds a granted index, registered.
REQ-008 pending_cnt  output  LIMIT+1  number of set bits in the pending register, registered.
REQ-009 overflow  output  1  one-cycle pulse, registered: a request merged into an already-pending bit.

Function
REQ-010 The block SHALL be the inverse of the team's one-hot select decoder: it encodes captured line events back into a binary index, one index per handshake.
REQ-011 Pending register: pend_next = (pend & ~clr) | path, where clr is the one-hot of the index loaded into the output stage this cycle, or zero if none is loaded.
REQ-012 Load condition: the output stage SHALL load when (!valid or ready) and pend != 0, using the pend value before this edge.
REQ-013 Selection SHALL be round-robin: the first set pend bit found scanning upward from ptr, wrapping from 2**LIMIT-1 to 0.
REQ-014 On a load: select <= selected index, valid <= 1, ptr <= (selected index + 1) mod 2**LIMIT.
REQ-015 When valid and ready and pend == 0: valid <= 0; select SHALL keep its last value.
REQ-016 When valid and !ready: select and valid SHALL hold unchanged; clr = 0.
REQ-017 Latency: path bit high in cycle N SHALL set pend at edge N; the earliest valid with that index is cycle N+2 (after edge N+1).
REQ-018 Throughput: with ready held high and pend nonzero, one index SHALL be presented per cycle.
REQ-019 Simultaneous request and clear on the same bit: the bit SHALL remain set as a new event; overflow SHALL NOT pulse.
REQ-020 overflow SHALL pulse for one cycle when path[k] = 1, pend[k] = 1 and clr[k] = 0 for any k; the event SHALL be merged, not counted twice.
REQ-021 pending_cnt SHALL equal the popcount of pend after the same edge; its range is 0..2**LIMIT.
REQ-022 All 2**LIMIT bits pending with ptr = 0 SHALL drain in order 0,1,...,2**LIMIT-1 when ready is held high and no new requests arrive.
REQ-023 The output stage is a single register; no index SHALL be lost or duplicated across stalls of any length.

Reset
REQ-024 While rst is high at an edge: pend = 0, ptr = 0, select = 0, valid = 0, pending_cnt = 0, overflow = 0.
REQ-025 rst SHALL take priority over path and ready in the same cycle; requests in a reset cycle SHALL be discarded.
REQ-026 rst mid-stall SHALL drop the presented index and all pending bits; the first cycle after reset SHALL show valid = 0.

Verification
REQ-027 Single event: path = 16'h0020 for one cycle with ready = 1 -> two cycles later valid = 1 and select = 5 for one cycle; pending_cnt goes 1 then 0.
REQ-028 Round robin: path = 16'h8011 for one cycle with ready = 1 -> select sequence 0, 4, 15 on consecutive cycles; pending_cnt 3, 2, 1, 0.
REQ-029 Stall: path = 16'h0006 with ready = 0 for 5 cycles -> select = 1 held for 5 cycles with valid = 1, pending_cnt = 1; after ready rises, select = 2 then valid = 0.
REQ-030 Overflow: bit 3 pending and stalled, path = 16'h0008 again -> overflow pulses for 1 cycle, pending_cnt stays 1, and index 3 is delivered once.
REQ-031 Wrap: ptr = 14 after granting 13, with pend = 16'h4001 -> select 14, then 0.
REQ-032 Reset mid-operation: pend = 16'hFFFF and valid = 1, assert rst for 1 cycle -> all outputs 0 next cycle; path = 16'h0000 thereafter keeps valid = 0.
